debug_uart_sched: RTL



---
 rtl/debug_uart_sched.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/debug_uart_sched.sv
// debug_uart_sched
//   Shares the debug UART transmitter between CPU byte writes, which are
//   buffered in a small FIFO, and a hardware trace byte source that uses a
//   req/ack handshake. When both are waiting, the requesters take turns.
//   uart_tx_en and uart_tx_data come straight from flops. No input reaches
//   them through combinational logic only.
//
// Ports
//   clk, rst_n          system clock, synchronous active-low reset
//   cpu_wr_en/_data     one-cycle push of a CPU byte
//   cpu_full            FIFO full (UART status bit)
//   cpu_level           bytes currently held in the FIFO (0..FIFO_DEPTH)
//   dropped             sticky: a CPU write was discarded
//   clr_dropped         one-cycle clear of dropped (a new drop wins)
//   trace_req/_data     trace byte offered, held until trace_ack
//   trace_ack           one-cycle pulse: trace byte consumed
//   uart_tx_en/_data    start pulse and byte towards uart_tx
//   uart_tx_busy        busy from uart_tx, rises the cycle after uart_tx_en
module debug_uart_sched #(
  parameter  int FIFO_DEPTH = 4,
  localparam int LW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cpu_wr_en,
  input  logic [7:0]    cpu_wr_data,
  output logic          cpu_full,
  output logic [LW-1:0] cpu_level,
  output logic          dropped,
  input  logic          clr_dropped,
  input  logic          trace_req,
  input  logic [7:0]    trace_data,
  output logic          trace_ack,
  output logic          uart_tx_en,
  output logic [7:0]    uart_tx_data,
  input  logic          uart_tx_busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          last_grant_trace;
  logic          grant_cpu;
  logic          grant_trace;
  logic          pop;
  logic          push;
  logic          drop;

  assign cpu_full = (cpu_level == FULL_LEVEL);

  // A CPU grant pops the FIFO at that same edge. That frees a slot, so a
  // write arriving while the FIFO is full is still accepted in that cycle.
  assign pop  = grant_cpu;
  assign push = cpu_wr_en && (!cpu_full || pop);
  assign drop = cpu_wr_en && !push;

  // Arbitration happens only in IDLE. If both requesters are waiting, the
  // one that did not win last time gets the grant.
  always_comb begin
    state_nxt   = state;
    grant_cpu   = 1'b0;
    grant_trace = 1'b0;
    case (state)
      IDLE: begin
        if ((cpu_level != '0) && (!trace_req || last_grant_trace)) begin
          grant_cpu = 1'b1;
        end else if (trace_req) begin
          grant_trace = 1'b1;
        end
        if (grant_cpu || grant_trace) begin
          state_nxt = LAUNCH;
        end
      end
      LAUNCH:    state_nxt = WAIT_BUSY;
      WAIT_BUSY: if (uart_tx_busy) state_nxt = WAIT_DONE;
      WAIT_DONE: if (!uart_tx_busy) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The FIFO storage has no reset. Its contents only count when cpu_level
  // says so.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= cpu_wr_data;
    end
  end

  // The launch pulse, trace_ack and the byte are all registered at the
  // grant edge. They therefore appear together in the LAUNCH cycle, and
  // the byte stays stable until the next grant.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      uart_tx_en       <= 1'b0;
      uart_tx_data     <= '0;
      trace_ack        <= 1'b0;
      last_grant_trace <= 1'b1;
    end else begin
      uart_tx_en <= grant_cpu || grant_trace;
      trace_ack  <= grant_trace;
      if (grant_cpu) begin
        uart_tx_data     <= mem[rd_ptr];
        last_grant_trace <= 1'b0;
      end else if (grant_trace) begin
        uart_tx_data     <= trace_data;
        last_grant_trace <= 1'b1;
      end
    end
  end

  // Pointers wrap naturally because FIFO_DEPTH is a power of two. The
  // level needs one extra bit so that it can reach FIFO_DEPTH.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      cpu_level <= '0;
      dropped   <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   cpu_level <= cpu_level + LW'(1);
        2'b01:   cpu_level <= cpu_level - LW'(1);
        default: cpu_level <= cpu_level;
      endcase
      if (drop) begin
        dropped <= 1'b1;
      end else if (clr_dropped) begin
        dropped <= 1'b0;
      end
    end
  end

endmodule
